// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and widths for the memory bus arbiter: FSM states, grant owner, counter widths.
package memory_bus_arbiter_pkg;

   localparam int unsigned AddrW       = 24;
   localparam int unsigned DataW       = 8;
   localparam int unsigned BurstCntW   = 4;
   localparam int unsigned TimeoutCntW = 16;

   typedef enum logic [1:0] {
      StIdle,
      StCpuAccess,
      StDmaAccess
   } state_e;

   typedef enum logic {
      GrantCpu = 1'b0,
      GrantDma = 1'b1
   } grant_e;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Requester and memory-side signal bundle; slave is the arbiter view, master the environment view.
interface memory_bus_arbiter_if;
   import memory_bus_arbiter_pkg::*;

   logic             cpu_req;
   logic [AddrW-1:0] cpu_address;
   logic [DataW-1:0] cpu_data_in;
   logic             cpu_write_enable;
   logic [DataW-1:0] cpu_data_out;
   logic             cpu_ack;
   logic             cpu_halt;

   logic             dma_req;
   logic [AddrW-1:0] dma_address;
   logic [DataW-1:0] dma_data_in;
   logic             dma_write_enable;
   logic [DataW-1:0] dma_data_out;
   logic             dma_ack;

   logic [AddrW-1:0] mem_address;
   logic [DataW-1:0] mem_data_out;
   logic [DataW-1:0] mem_data_in;
   logic             mem_bus_enable;
   logic             mem_write_enable;
   logic             mem_bus_halt;

   logic             error;

   modport slave (
      input  cpu_req, cpu_address, cpu_data_in, cpu_write_enable,
      input  dma_req, dma_address, dma_data_in, dma_write_enable,
      input  mem_data_in, mem_bus_halt,
      output cpu_data_out, cpu_ack, cpu_halt,
      output dma_data_out, dma_ack,
      output mem_address, mem_data_out, mem_bus_enable, mem_write_enable,
      output error
   );

   modport master (
      output cpu_req, cpu_address, cpu_data_in, cpu_write_enable,
      output dma_req, dma_address, dma_data_in, dma_write_enable,
      output mem_data_in, mem_bus_halt,
      input  cpu_data_out, cpu_ack, cpu_halt,
      input  dma_data_out, dma_ack,
      input  mem_address, mem_data_out, mem_bus_enable, mem_write_enable,
      input  error
   );

endinterface

// File: rtl/memory_bus_arbiter_select.sv
// Stateless CPU/DMA grant decision; DMA may run up to DMA_BURST grants ahead of a waiting CPU.
module arbiter_select
   import memory_bus_arbiter_pkg::*;
#(
   parameter int unsigned DMA_BURST = 4
) (
   input  logic                 cpu_req_i,
   input  logic                 dma_req_i,
   input  grant_e               last_grant_i,
   input  logic [BurstCntW-1:0] burst_count_i,
   output logic                 grant_cpu_o,
   output logic                 grant_dma_o
);

   logic dma_turn;

   assign dma_turn = (last_grant_i == GrantCpu) ||
                     (burst_count_i < BurstCntW'(DMA_BURST));

   always_comb begin
      grant_cpu_o = 1'b0;
      grant_dma_o = 1'b0;
      if (cpu_req_i && dma_req_i) begin
         grant_dma_o = dma_turn;
         grant_cpu_o = !dma_turn;
      end else begin
         grant_cpu_o = cpu_req_i;
         grant_dma_o = dma_req_i;
      end
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-requester memory bus arbiter with halt-aware access sequencing.
// Optional halt timeout abort enabled by defining ARBITER_TIMEOUT_EN.
module memory_bus_arbiter
   import memory_bus_arbiter_pkg::*;
#(
   parameter int unsigned DMA_BURST      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic                 clk_i,
   input logic                 reset_i,
   memory_bus_arbiter_if.slave bus_io
);

   state_e               state_q, state_d;
   grant_e               last_grant_q, last_grant_d;
   logic [BurstCntW-1:0] burst_q, burst_d;
   logic [AddrW-1:0]     mem_addr_q, mem_addr_d;
   logic [DataW-1:0]     mem_wdata_q, mem_wdata_d;
   logic                 mem_en_q, mem_en_d;
   logic                 mem_we_q, mem_we_d;
   logic [DataW-1:0]     cpu_rdata_q, cpu_rdata_d;
   logic [DataW-1:0]     dma_rdata_q, dma_rdata_d;
   logic                 cpu_ack_q, cpu_ack_d;
   logic                 dma_ack_q, dma_ack_d;
   logic                 grant_cpu, grant_dma;
   logic                 done;
   logic [DataW-1:0]     done_data;
`ifdef ARBITER_TIMEOUT_EN
   logic [TimeoutCntW-1:0] halt_cnt_q, halt_cnt_d;
   logic                   error_q, error_d;
`else
   logic [31:0]            unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
`endif

   arbiter_select #(
      .DMA_BURST (DMA_BURST)
   ) u_select (
      .cpu_req_i     (bus_io.cpu_req),
      .dma_req_i     (bus_io.dma_req),
      .last_grant_i  (last_grant_q),
      .burst_count_i (burst_q),
      .grant_cpu_o   (grant_cpu),
      .grant_dma_o   (grant_dma)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      burst_d      = burst_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_en_d     = mem_en_q;
      mem_we_d     = mem_we_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      cpu_ack_d    = 1'b0;
      dma_ack_d    = 1'b0;
      done         = 1'b0;
      done_data    = bus_io.mem_data_in;
`ifdef ARBITER_TIMEOUT_EN
      halt_cnt_d   = halt_cnt_q;
      error_d      = error_q;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef ARBITER_TIMEOUT_EN
            halt_cnt_d = '0;
`endif
            if (grant_cpu) begin
               mem_addr_d   = bus_io.cpu_address;
               mem_wdata_d  = bus_io.cpu_data_in;
               mem_we_d     = bus_io.cpu_write_enable;
               mem_en_d     = 1'b1;
               last_grant_d = GrantCpu;
               burst_d      = '0;
               state_d      = StCpuAccess;
            end else if (grant_dma) begin
               mem_addr_d   = bus_io.dma_address;
               mem_wdata_d  = bus_io.dma_data_in;
               mem_we_d     = bus_io.dma_write_enable;
               mem_en_d     = 1'b1;
               last_grant_d = GrantDma;
               // Only grants that make a waiting CPU wait count toward the burst
               if (bus_io.cpu_req && (burst_q != '1)) begin
                  burst_d = burst_q + 1'b1;
               end
               state_d      = StDmaAccess;
            end
         end
         StCpuAccess, StDmaAccess: begin
            if (!bus_io.mem_bus_halt) begin
               done = 1'b1;
`ifdef ARBITER_TIMEOUT_EN
            end else if (halt_cnt_q == TimeoutCntW'(TIMEOUT_CYCLES - 1)) begin
               done      = 1'b1;
               done_data = 8'hFF;
               error_d   = 1'b1;
            end else begin
               halt_cnt_d = halt_cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      if (done) begin
         mem_en_d = 1'b0;
         mem_we_d = 1'b0;
         state_d  = StIdle;
         if (state_q == StCpuAccess) begin
            cpu_rdata_d = done_data;
            cpu_ack_d   = 1'b1;
         end else begin
            dma_rdata_d = done_data;
            dma_ack_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         last_grant_q <= GrantDma;
         burst_q      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
         halt_cnt_q   <= '0;
         error_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         burst_q      <= burst_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dma_ack_q    <= dma_ack_d;
`ifdef ARBITER_TIMEOUT_EN
         halt_cnt_q   <= halt_cnt_d;
         error_q      <= error_d;
`endif
      end
   end

   assign bus_io.mem_address      = mem_addr_q;
   assign bus_io.mem_data_out     = mem_wdata_q;
   assign bus_io.mem_bus_enable   = mem_en_q;
   assign bus_io.mem_write_enable = mem_we_q;
   assign bus_io.cpu_data_out     = cpu_rdata_q;
   assign bus_io.dma_data_out     = dma_rdata_q;
   assign bus_io.cpu_ack          = cpu_ack_q;
   assign bus_io.dma_ack          = dma_ack_q;
   assign bus_io.cpu_halt         = bus_io.cpu_req & ~cpu_ack_q;
`ifdef ARBITER_TIMEOUT_EN
   assign bus_io.error            = error_q;
`else
   assign bus_io.error            = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter; inputs driven and outputs sampled on negedge.
module tb_memory_bus_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   memory_bus_arbiter_if bus ();

   memory_bus_arbiter #(
      .DMA_BURST      (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_io  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int  n_pre;
      int  n_after;
      int  n_not_halted;
      bit  cpu_on;
      bit  fin;
      bit  exp_cpu;

      bus.cpu_req = 1'b0; bus.cpu_address = '0; bus.cpu_data_in = '0; bus.cpu_write_enable = 1'b0;
      bus.dma_req = 1'b0; bus.dma_address = '0; bus.dma_data_in = '0; bus.dma_write_enable = 1'b0;
      bus.mem_data_in = '0; bus.mem_bus_halt = 1'b0;
      repeat (2) tick();
      check("rst_mem_en", bus.mem_bus_enable, 0);
      check("rst_mem_we", bus.mem_write_enable, 0);
      check("rst_mem_addr", bus.mem_address, 0);
      check("rst_mem_wdata", bus.mem_data_out, 0);
      check("rst_acks", {bus.cpu_ack, bus.dma_ack}, 0);
      check("rst_rdata", {bus.cpu_data_out, bus.dma_data_out}, 0);
      check("rst_error", bus.error, 0);
      reset = 1'b0;

      // CPU read, no halt
      bus.cpu_req = 1'b1; bus.cpu_address = 24'h004010; bus.cpu_write_enable = 1'b0;
      bus.mem_data_in = 8'h5A;
      tick();
      check("rd_en", bus.mem_bus_enable, 1);
      check("rd_addr", bus.mem_address, 24'h004010);
      check("rd_we", bus.mem_write_enable, 0);
      check("rd_ack_early", bus.cpu_ack, 0);
      check("rd_cpu_halt", bus.cpu_halt, 1);
      tick();
      check("rd_ack", bus.cpu_ack, 1);
      check("rd_data", bus.cpu_data_out, 8'h5A);
      check("rd_en_drop", bus.mem_bus_enable, 0);
      check("rd_dma_ack", bus.dma_ack, 0);
      check("rd_cpu_halt_ack", bus.cpu_halt, 0);
      bus.cpu_req = 1'b0;
      tick();
      check("rd_ack_pulse", bus.cpu_ack, 0);
      check("rd_no_regrant", bus.mem_bus_enable, 0);
      check("rd_data_hold", bus.cpu_data_out, 8'h5A);

      // DMA write held off by 5 halt cycles
      bus.dma_req = 1'b1; bus.dma_address = 24'h0000F0; bus.dma_data_in = 8'hC3;
      bus.dma_write_enable = 1'b1; bus.mem_bus_halt = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("wr_stable_%0d", i),
               {bus.mem_bus_enable, bus.mem_write_enable, bus.mem_address, bus.mem_data_out},
               {1'b1, 1'b1, 24'h0000F0, 8'hC3});
         check($sformatf("wr_noack_%0d", i), bus.dma_ack, 0);
         if (i == 5) bus.mem_bus_halt = 1'b0;
      end
      tick();
      check("wr_ack", bus.dma_ack, 1);
      check("wr_en_drop", {bus.mem_bus_enable, bus.mem_write_enable}, 0);
      bus.dma_req = 1'b0; bus.dma_write_enable = 1'b0;
      tick();
      check("wr_ack_pulse", bus.dma_ack, 0);

      // Both requesting, each dropping req in its own ack cycle: alternating grants
      bus.cpu_address = 24'h000100; bus.dma_address = 24'h000200;
      bus.mem_data_in = 8'h3C;
      bus.cpu_req = 1'b1;
      exp_cpu = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("alt_addr_%0d", k), bus.mem_address,
               exp_cpu ? 24'h000100 : 24'h000200);
         bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
         tick();
         check($sformatf("alt_acks_%0d", k), {bus.cpu_ack, bus.dma_ack}, {exp_cpu, !exp_cpu});
         if (exp_cpu) bus.cpu_req = 1'b0;
         else bus.dma_req = 1'b0;
         exp_cpu = !exp_cpu;
      end
      bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
      tick();

      // DMA streaming alone for 6 accesses, then CPU joins: exactly 4 more DMA grants
      n_pre = 0; n_after = 0; cpu_on = 1'b0; fin = 1'b0;
      bus.dma_req = 1'b1;
      for (int c = 0; c < 80 && !fin; c++) begin
         tick();
         if (bus.dma_ack) begin
            if (cpu_on) n_after++;
            else begin
               n_pre++;
               if (n_pre == 6) begin
                  cpu_on = 1'b1;
                  bus.cpu_req = 1'b1;
               end
            end
         end
         if (bus.cpu_ack) begin
            fin = 1'b1;
            bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
         end
      end
      check("burst_cpu_served", fin, 1);
      check("burst_dma_grants", n_after, 4);
      bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
      tick();

      // Reset during a halted CPU access
      bus.cpu_req = 1'b1; bus.cpu_address = 24'h000777; bus.mem_bus_halt = 1'b1;
      bus.mem_data_in = 8'h99;
      tick();
      check("rst_mid_en", bus.mem_bus_enable, 1);
      reset = 1'b1;
      tick();
      check("rst_mid_en_drop", bus.mem_bus_enable, 0);
      check("rst_mid_ack", bus.cpu_ack, 0);
      check("rst_mid_data", bus.cpu_data_out, 0);
      reset = 1'b0; bus.cpu_req = 1'b0; bus.mem_bus_halt = 1'b0;
      tick();
      check("rst_mid_idle", {bus.mem_bus_enable, bus.cpu_ack}, 0);

`ifdef ARBITER_TIMEOUT_EN
      // Stuck halt aborts on the 16th halt cycle
      bus.cpu_req = 1'b1; bus.cpu_address = 24'h120000; bus.mem_bus_halt = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check($sformatf("to_wait_%0d", i), {bus.cpu_ack, bus.error}, 0);
      end
      tick();
      check("to_ack", bus.cpu_ack, 1);
      check("to_data", bus.cpu_data_out, 8'hFF);
      check("to_error", bus.error, 1);
      bus.cpu_req = 1'b0; bus.mem_bus_halt = 1'b0;
      repeat (3) tick();
      check("to_error_sticky", bus.error, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("to_error_clr", bus.error, 0);
`else
      // Slow SD fill: 100 halt cycles, then data
      bus.cpu_req = 1'b1; bus.cpu_address = 24'h120000; bus.cpu_write_enable = 1'b0;
      bus.mem_bus_halt = 1'b1; bus.mem_data_in = 8'h00;
      n_not_halted = 0;
      for (int i = 0; i <= 100; i++) begin
         tick();
         if (bus.cpu_halt !== 1'b1 || bus.cpu_ack !== 1'b0) n_not_halted++;
         if (i == 100) begin
            bus.mem_bus_halt = 1'b0;
            bus.mem_data_in = 8'h11;
         end
      end
      check("sd_halt_held", n_not_halted, 0);
      check("sd_error", bus.error, 0);
      tick();
      check("sd_ack", bus.cpu_ack, 1);
      check("sd_data", bus.cpu_data_out, 8'h11);
      check("sd_cpu_halt_ack", bus.cpu_halt, 0);
      bus.cpu_req = 1'b0;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
